// File: rtl/ysyx_23060208_axil_xbar.sv
// ysyx_23060208_axil_xbar: NM-master / NS-slave AXI4-Lite crossbar with independent round-robin read and write paths.
module ysyx_23060208_axil_xbar #(
  parameter int NM = 2,
  parameter int NS = 3,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter logic [NS*AW-1:0] SLV_BASE = {32'ha000_0048, 32'ha000_03f8, 32'h8000_0000},
  parameter logic [NS*AW-1:0] SLV_MASK = {32'hffff_fff8, 32'hffff_fff8, 32'hf800_0000}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NM*AW-1:0]     m_awaddr,
  input  logic [NM-1:0]        m_awvalid,
  output logic [NM-1:0]        m_awready,
  input  logic [NM*DW-1:0]     m_wdata,
  input  logic [NM*DW/8-1:0]   m_wstrb,
  input  logic [NM-1:0]        m_wvalid,
  output logic [NM-1:0]        m_wready,
  output logic [NM*2-1:0]      m_bresp,
  output logic [NM-1:0]        m_bvalid,
  input  logic [NM-1:0]        m_bready,
  input  logic [NM*AW-1:0]     m_araddr,
  input  logic [NM-1:0]        m_arvalid,
  output logic [NM-1:0]        m_arready,
  output logic [NM*DW-1:0]     m_rdata,
  output logic [NM*2-1:0]      m_rresp,
  output logic [NM-1:0]        m_rvalid,
  input  logic [NM-1:0]        m_rready,
  output logic [NS*AW-1:0]     s_awaddr,
  output logic [NS-1:0]        s_awvalid,
  input  logic [NS-1:0]        s_awready,
  output logic [NS*DW-1:0]     s_wdata,
  output logic [NS*DW/8-1:0]   s_wstrb,
  output logic [NS-1:0]        s_wvalid,
  input  logic [NS-1:0]        s_wready,
  input  logic [NS*2-1:0]      s_bresp,
  input  logic [NS-1:0]        s_bvalid,
  output logic [NS-1:0]        s_bready,
  output logic [NS*AW-1:0]     s_araddr,
  output logic [NS-1:0]        s_arvalid,
  input  logic [NS-1:0]        s_arready,
  input  logic [NS*DW-1:0]     s_rdata,
  input  logic [NS*2-1:0]      s_rresp,
  input  logic [NS-1:0]        s_rvalid,
  output logic [NS-1:0]        s_rready
);
  localparam int MW = NM > 1 ? $clog2(NM) : 1;
  localparam int SW = NS > 1 ? $clog2(NS) : 1;
  localparam int SB = DW / 8;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP, W_ERR} w_state_t;
  // First requester at or after ptr, wrapping; the smallest offset wins.
  function automatic logic [MW-1:0] rr_pick(input logic [NM-1:0] req, input logic [MW-1:0] ptr);
    int idx;
    rr_pick = ptr;
    for (int k = NM - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NM;
      if (req[idx]) rr_pick = MW'(idx);
    end
  endfunction
  // {hit, slave}; scanning downwards lets the lowest matching index win.
  function automatic logic [SW:0] dec(input logic [AW-1:0] a);
    dec = '0;
    for (int i = NS - 1; i >= 0; i--)
      if ((a & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) dec = {1'b1, SW'(i)};
  endfunction
  r_state_t rs;
  logic [MW-1:0] rg, rr_r, r_pick, r_nxt;
  logic [SW-1:0] rsl;
  logic [SW:0] r_dec;
  logic r_ar_done, ar_hs, r_hs;
  assign r_pick = rr_pick(m_arvalid, rr_r);
  assign r_dec = dec(m_araddr[int'(r_pick)*AW +: AW]);
  assign r_nxt = (rg == MW'(NM - 1)) ? '0 : rg + 1'b1;
  assign ar_hs = m_arvalid[rg] & m_arready[rg];
  assign r_hs = m_rvalid[rg] & m_rready[rg];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rs <= R_IDLE;
      rg <= '0;
      rsl <= '0;
      rr_r <= '0;
      r_ar_done <= 1'b0;
    end else case (rs)
      R_IDLE: if (|m_arvalid) begin
        rg <= r_pick;
        rsl <= r_dec[SW-1:0];
        r_ar_done <= 1'b0;
        rs <= r_dec[SW] ? R_ADDR : R_ERR;
      end
      R_ADDR: if (ar_hs) rs <= R_DATA;
      R_DATA: if (r_hs) begin
        rs <= R_IDLE;
        rr_r <= r_nxt;
      end
      R_ERR: begin
        if (ar_hs) r_ar_done <= 1'b1;
        if (r_hs) begin
          rs <= R_IDLE;
          rr_r <= r_nxt;
        end
      end
    endcase
  always_comb begin
    s_arvalid = '0;
    s_araddr = '0;
    s_rready = '0;
    m_arready = '0;
    m_rvalid = '0;
    m_rdata = '0;
    m_rresp = '0;
    if (rs == R_ADDR) begin
      s_arvalid[rsl] = m_arvalid[rg];
      s_araddr[int'(rsl)*AW +: AW] = m_araddr[int'(rg)*AW +: AW];
      m_arready[rg] = s_arready[rsl];
    end
    if (rs == R_DATA) begin
      s_rready[rsl] = m_rready[rg];
      m_rvalid[rg] = s_rvalid[rsl];
      m_rdata[int'(rg)*DW +: DW] = s_rdata[int'(rsl)*DW +: DW];
      m_rresp[int'(rg)*2 +: 2] = s_rresp[int'(rsl)*2 +: 2];
    end
    if (rs == R_ERR) begin
      m_arready[rg] = ~r_ar_done;
      m_rvalid[rg] = r_ar_done;
      m_rresp[int'(rg)*2 +: 2] = 2'b11;
    end
  end
  w_state_t ws;
  logic [MW-1:0] wg, wrr_r, w_pick, w_nxt;
  logic [SW-1:0] wsl;
  logic [SW:0] w_dec;
  logic aw_done, w_done, aw_hs, w_hs, b_hs;
  assign w_pick = rr_pick(m_awvalid, wrr_r);
  assign w_dec = dec(m_awaddr[int'(w_pick)*AW +: AW]);
  assign w_nxt = (wg == MW'(NM - 1)) ? '0 : wg + 1'b1;
  assign aw_hs = m_awvalid[wg] & m_awready[wg];
  assign w_hs = m_wvalid[wg] & m_wready[wg];
  assign b_hs = m_bvalid[wg] & m_bready[wg];
  // AW and W complete independently; the done flags mask each channel once it has handshaken.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ws <= W_IDLE;
      wg <= '0;
      wsl <= '0;
      wrr_r <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else case (ws)
      W_IDLE: if (|m_awvalid) begin
        wg <= w_pick;
        wsl <= w_dec[SW-1:0];
        aw_done <= 1'b0;
        w_done <= 1'b0;
        ws <= w_dec[SW] ? W_ADDR : W_ERR;
      end
      W_ADDR: begin
        aw_done <= aw_done | aw_hs;
        w_done <= w_done | w_hs;
        if ((aw_done | aw_hs) && (w_done | w_hs)) ws <= W_RESP;
      end
      W_RESP: if (b_hs) begin
        ws <= W_IDLE;
        wrr_r <= w_nxt;
      end
      W_ERR: begin
        aw_done <= aw_done | aw_hs;
        w_done <= w_done | w_hs;
        if (b_hs) begin
          ws <= W_IDLE;
          wrr_r <= w_nxt;
        end
      end
    endcase
  always_comb begin
    s_awvalid = '0;
    s_awaddr = '0;
    s_wvalid = '0;
    s_wdata = '0;
    s_wstrb = '0;
    s_bready = '0;
    m_awready = '0;
    m_wready = '0;
    m_bvalid = '0;
    m_bresp = '0;
    if (ws == W_ADDR) begin
      s_awvalid[wsl] = m_awvalid[wg] & ~aw_done;
      s_awaddr[int'(wsl)*AW +: AW] = m_awaddr[int'(wg)*AW +: AW];
      m_awready[wg] = s_awready[wsl] & ~aw_done;
      s_wvalid[wsl] = m_wvalid[wg] & ~w_done;
      s_wdata[int'(wsl)*DW +: DW] = m_wdata[int'(wg)*DW +: DW];
      s_wstrb[int'(wsl)*SB +: SB] = m_wstrb[int'(wg)*SB +: SB];
      m_wready[wg] = s_wready[wsl] & ~w_done;
    end
    if (ws == W_RESP) begin
      s_bready[wsl] = m_bready[wg];
      m_bvalid[wg] = s_bvalid[wsl];
      m_bresp[int'(wg)*2 +: 2] = s_bresp[int'(wsl)*2 +: 2];
    end
    if (ws == W_ERR) begin
      m_awready[wg] = ~aw_done;
      m_wready[wg] = ~w_done;
      m_bvalid[wg] = aw_done & w_done;
      m_bresp[int'(wg)*2 +: 2] = 2'b11;
    end
  end
endmodule
